exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle execution controller for the core. Sits between the fetch stage, the instruction decoder, the ALU branch-compare result and the LSU bus. It drives the decoder's `cycle_counter_i`, gates register-file writes, and sequences PC updates, memory handshakes and traps. It retires exactly one instruction or takes exactly one trap per consumed instruction.

## Interface
Parameters:
- `LSU_TIMEOUT`, default 255: maximum number of cycles spent in the memory states before a bus-fault trap is taken. 0 disables the timeout. Counter width is `$clog2(LSU_TIMEOUT+1)`.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `instr_valid_i` in 1: fetch presents an instruction. The instruction and all decoder outputs stay stable until `instr_ready_o`.
- `instr_ready_o` out 1: the current instruction is consumed this cycle.
- `rf_we_i`, `jump_inst_i`, `branch_inst_i`, `lsu_r_en_i`, `lsu_w_en_i`, `ecall_inst_i`, `ebreak_inst_i`, `mret_inst_i`, `illegal_inst_i` in 1 each: decoder outputs.
- `branch_taken_i` in 1: ALU compare result (bit 0) during branch cycle 0.
- `cycle_counter_o` out 1: drives the decoder `cycle_counter_i`.
- `rf_we_o` out 1: gated register-file write enable.
- `pc_we_o` out 1: PC update strobe.
- `pc_sel_o` out 2: PC source. 0 = PC+inc, 1 = ALU out, 2 = mtvec, 3 = mepc.
- `flush_o` out 1: discard prefetched instructions; asserted with every non-sequential PC write.
- `lsu_req_o` out 1: memory request.
- `lsu_gnt_i` in 1: request accepted.
- `lsu_rvalid_i` in 1: access complete (load data or store ack).
- `trap_o` out 1: trap taken this cycle.
- `trap_cause_o` out 4: mcause code, valid with `trap_o`.
- `mret_o` out 1: mret executes this cycle.
- `retire_o` out 1: one instruction retired (feeds minstret).

## Operation
- States: EXEC, EXEC2, MEM_REQ, MEM_WAIT. Reset state is EXEC.
- `cycle_counter_o` is 1 only in EXEC2, otherwise 0.
- EXEC with `instr_valid_i` low: all outputs 0, state unchanged.
- EXEC with `instr_valid_i` high: priority is illegal > ecall > ebreak > mret > jump > branch > load/store > plain.
- Trap (single cycle, from EXEC):
  - Outputs: `trap_o`=1, `pc_we_o`=1, `pc_sel_o`=2, `flush_o`=1, `instr_ready_o`=1, `rf_we_o`=0, `retire_o`=0.
  - Causes: illegal → 2, ebreak → 3, ecall → 11.
- mret: `mret_o`, `pc_we_o`, `pc_sel_o`=3, `flush_o`, `instr_ready_o`, `retire_o`; single cycle.
- Plain ALU/LUI/AUIPC/CSR: `rf_we_o`=`rf_we_i`, `pc_we_o`, `pc_sel_o`=0, `instr_ready_o`, `retire_o`; single cycle.
- Jump:
  - EXEC: `rf_we_o`=`rf_we_i` (link write); go to EXEC2.
  - EXEC2: `rf_we_o`=0, `pc_we_o`, `pc_sel_o`=1, `flush_o`, `instr_ready_o`, `retire_o`; go to EXEC.
- Branch:
  - EXEC with `branch_taken_i`=0: `pc_sel_o`=0, `pc_we_o`, `instr_ready_o`, `retire_o`; stay in EXEC.
  - EXEC with `branch_taken_i`=1: go to EXEC2, which behaves as for a jump.
- Load/store:
  - EXEC goes to MEM_REQ with no outputs.
  - MEM_REQ: `lsu_req_o`=1 until `lsu_gnt_i`, then go to MEM_WAIT.
  - MEM_WAIT: `lsu_req_o`=0. On `lsu_rvalid_i`: `rf_we_o`=`rf_we_i` (loads only), `pc_we_o`, `pc_sel_o`=0, `instr_ready_o`, `retire_o`; go to EXEC.
  - `lsu_rvalid_i` is ignored outside MEM_WAIT. `lsu_gnt_i` is ignored outside MEM_REQ.
- Timeout:
  - The counter clears on entry to MEM_REQ and increments each cycle in MEM_REQ/MEM_WAIT.
  - If the counter equals `LSU_TIMEOUT` and completion does not arrive that cycle: trap with cause 5 (load) or 7 (store), `lsu_req_o`=0, no RF write, go to EXEC.
  - `lsu_rvalid_i` in the same cycle as the timeout wins: normal completion.
- Invariant: `instr_ready_o` is high for exactly one cycle per instruction and coincides with exactly one of `retire_o` or `trap_o`.

## Timing
- Reset: while `rst_i` is high every output is 0. Next edge gives state EXEC and counter 0.
- Reset mid-operation (EXEC2/MEM_*): the instruction is abandoned and `lsu_req_o` drops in the reset cycle.
- Latencies in cycles:
  - Plain, trap, mret, untaken branch: 1.
  - Jump, taken branch: 2.
  - Load/store: 1 + (cycles to gnt, minimum 1) + (cycles to rvalid, minimum 1). Minimum total is 3.
- All state and counter updates are registered. Outputs are combinational from state and inputs (Mealy); no combinational path from `lsu_rvalid_i` to `lsu_req_o`.
- `instr_valid_i` dropping while not in EXEC is a protocol violation; behaviour is undefined.

## Test plan
- ADDI with valid held: `rf_we_o`, `pc_we_o` (sel 0), `instr_ready_o`, `retire_o` all 1 in the same single cycle; `cycle_counter_o`=0.
- JAL: cycle 0 gives `rf_we_o`=1, `pc_we_o`=0. Cycle 1 gives `cycle_counter_o`=1, `pc_sel_o`=1, `flush_o`=1, `retire_o`=1.
- BEQ: with taken=0, retire in 1 cycle with sel 0. With taken=1, retire in 2 cycles with sel 1 and flush.
- LW with gnt after 2 cycles of req and rvalid 3 cycles later: `lsu_req_o` high exactly 2 cycles; `rf_we_o`=1 only on the rvalid cycle; total 6 cycles.
- SW with `LSU_TIMEOUT`=4 and no gnt: trap in cycle 5 with cause 7, `pc_sel_o`=2, `rf_we_o`=0, `retire_o`=0. A stray rvalid afterwards is ignored.
- `illegal_inst_i` together with `jump_inst_i`: trap cause 2, no link write. `rst_i` in MEM_WAIT: outputs 0 and the next valid instruction decodes in EXEC.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - fetch handshake and LSU bus bundle for exec_sequencer
//
// Purpose: groups the instruction handshake and the LSU request/grant/
// completion signals so the sequencer and its environment share one bundle.
// Signals:
//   instr_valid  fetch -> sequencer, instruction presented
//   instr_ready  sequencer -> fetch, instruction consumed this cycle
//   lsu_req      sequencer -> LSU, memory request
//   lsu_gnt      LSU -> sequencer, request accepted
//   lsu_rvalid   LSU -> sequencer, access complete (load data or store ack)
// Modports: master = sequencer view, slave = fetch/LSU view.
interface exec_sequencer_if;
  logic instr_valid;
  logic instr_ready;
  logic lsu_req;
  logic lsu_gnt;
  logic lsu_rvalid;

  modport master (
    input  instr_valid,
    output instr_ready,
    output lsu_req,
    input  lsu_gnt,
    input  lsu_rvalid
  );

  modport slave (
    output instr_valid,
    input  instr_ready,
    input  lsu_req,
    output lsu_gnt,
    output lsu_rvalid
  );
endinterface

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle execution controller (retire/trap sequencing)
//
// Purpose: sequences PC updates, register-file write gating, LSU handshakes
// and traps so that each consumed instruction either retires or traps once.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   bus                   fetch handshake + LSU bus (exec_sequencer_if.master)
//   rf_we_i .. illegal_inst_i  decoder outputs, stable until instr_ready
//   branch_taken_i        ALU compare result during branch cycle 0
//   cycle_counter_o       decoder cycle select (1 only in EXEC2)
//   rf_we_o               gated register-file write enable
//   pc_we_o, pc_sel_o     PC update strobe and source (0 +inc, 1 ALU, 2 mtvec, 3 mepc)
//   flush_o               discard prefetch on non-sequential PC write
//   trap_o, trap_cause_o  trap taken and its mcause code
//   mret_o, retire_o      mret executing, instruction retired
module exec_sequencer #(
  parameter int unsigned LSU_TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  exec_sequencer_if.master    bus,
  input  logic                rf_we_i,
  input  logic                jump_inst_i,
  input  logic                branch_inst_i,
  input  logic                lsu_r_en_i,
  input  logic                lsu_w_en_i,
  input  logic                ecall_inst_i,
  input  logic                ebreak_inst_i,
  input  logic                mret_inst_i,
  input  logic                illegal_inst_i,
  input  logic                branch_taken_i,
  output logic                cycle_counter_o,
  output logic                rf_we_o,
  output logic                pc_we_o,
  output logic [1:0]          pc_sel_o,
  output logic                flush_o,
  output logic                trap_o,
  output logic [3:0]          trap_cause_o,
  output logic                mret_o,
  output logic                retire_o
);

  // A zero timeout disables the counter, but it still needs one bit to exist.
  localparam int unsigned CNT_W = (LSU_TIMEOUT > 0) ? $clog2(LSU_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(LSU_TIMEOUT);
  localparam bit TIMEOUT_EN = (LSU_TIMEOUT != 0);

  localparam logic [1:0] PC_INC   = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_MTVEC = 2'd2;
  localparam logic [1:0] PC_MEPC  = 2'd3;

  typedef enum logic [1:0] {
    EXEC     = 2'd0,
    EXEC2    = 2'd1,
    MEM_REQ  = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;
  logic             instr_ready;
  logic             lsu_req;

  assign timeout_hit     = TIMEOUT_EN && (cnt_q == TIMEOUT_CNT);
  assign bus.instr_ready = instr_ready;
  assign bus.lsu_req     = lsu_req;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EXEC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    instr_ready     = 1'b0;
    lsu_req         = 1'b0;
    cycle_counter_o = 1'b0;
    rf_we_o         = 1'b0;
    pc_we_o         = 1'b0;
    pc_sel_o        = PC_INC;
    flush_o         = 1'b0;
    trap_o          = 1'b0;
    trap_cause_o    = 4'd0;
    mret_o          = 1'b0;
    retire_o        = 1'b0;

    // Every output stays low during reset, so the whole decode is skipped.
    if (!rst_i) begin
      case (state_q)
        EXEC: begin
          if (bus.instr_valid) begin
            if (illegal_inst_i || ecall_inst_i || ebreak_inst_i) begin
              trap_o       = 1'b1;
              pc_we_o      = 1'b1;
              pc_sel_o     = PC_MTVEC;
              flush_o      = 1'b1;
              instr_ready  = 1'b1;
              trap_cause_o = illegal_inst_i ? 4'd2 : (ecall_inst_i ? 4'd11 : 4'd3);
            end else if (mret_inst_i) begin
              mret_o      = 1'b1;
              pc_we_o     = 1'b1;
              pc_sel_o    = PC_MEPC;
              flush_o     = 1'b1;
              instr_ready = 1'b1;
              retire_o    = 1'b1;
            end else if (jump_inst_i) begin
              // Link register is written now; the PC moves in EXEC2.
              rf_we_o = rf_we_i;
              state_d = EXEC2;
            end else if (branch_inst_i && branch_taken_i) begin
              state_d = EXEC2;
            end else if (lsu_r_en_i || lsu_w_en_i) begin
              state_d = MEM_REQ;
              cnt_d   = '0;
            end else begin
              // Plain instruction or untaken branch.
              rf_we_o     = rf_we_i && !branch_inst_i;
              pc_we_o     = 1'b1;
              instr_ready = 1'b1;
              retire_o    = 1'b1;
            end
          end
        end

        EXEC2: begin
          cycle_counter_o = 1'b1;
          pc_we_o         = 1'b1;
          pc_sel_o        = PC_ALU;
          flush_o         = 1'b1;
          instr_ready     = 1'b1;
          retire_o        = 1'b1;
          state_d         = EXEC;
        end

        MEM_REQ, MEM_WAIT: begin
          // Completion only counts while waiting; it beats a same-cycle timeout.
          if (state_q == MEM_WAIT && bus.lsu_rvalid) begin
            rf_we_o     = rf_we_i && lsu_r_en_i;
            pc_we_o     = 1'b1;
            instr_ready = 1'b1;
            retire_o    = 1'b1;
            state_d     = EXEC;
            cnt_d       = '0;
          end else if (timeout_hit) begin
            trap_o       = 1'b1;
            pc_we_o      = 1'b1;
            pc_sel_o     = PC_MTVEC;
            flush_o      = 1'b1;
            instr_ready  = 1'b1;
            trap_cause_o = lsu_w_en_i ? 4'd7 : 4'd5;
            state_d      = EXEC;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == MEM_REQ) begin
              lsu_req = 1'b1;
              if (bus.lsu_gnt) begin
                state_d = MEM_WAIT;
              end
            end
          end
        end

        default: state_d = EXEC;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed self-checking bench for exec_sequencer
module tb_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rf_we, jump, branch, ld, st, ecall, ebreak, mret, illegal, taken;
  logic       cc_o, rf_we_o, pc_we_o, flush_o, trap_o, mret_o, retire_o;
  logic [1:0] pc_sel_o;
  logic [3:0] cause_o;

  int errs   = 0;
  int checks = 0;

  exec_sequencer_if bus_if ();

  exec_sequencer #(.LSU_TIMEOUT(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus             (bus_if),
    .rf_we_i         (rf_we),
    .jump_inst_i     (jump),
    .branch_inst_i   (branch),
    .lsu_r_en_i      (ld),
    .lsu_w_en_i      (st),
    .ecall_inst_i    (ecall),
    .ebreak_inst_i   (ebreak),
    .mret_inst_i     (mret),
    .illegal_inst_i  (illegal),
    .branch_taken_i  (taken),
    .cycle_counter_o (cc_o),
    .rf_we_o         (rf_we_o),
    .pc_we_o         (pc_we_o),
    .pc_sel_o        (pc_sel_o),
    .flush_o         (flush_o),
    .trap_o          (trap_o),
    .trap_cause_o    (cause_o),
    .mret_o          (mret_o),
    .retire_o        (retire_o)
  );

  always #5 clk = ~clk;

  // Instruction encodings: {illegal, mret, ebreak, ecall, st, ld, branch, jump, rf_we}
  localparam logic [8:0] I_NONE   = 9'b0_0000_0000;
  localparam logic [8:0] I_ADDI   = 9'b0_0000_0001;
  localparam logic [8:0] I_JAL    = 9'b0_0000_0011;
  localparam logic [8:0] I_BEQ    = 9'b0_0000_0100;
  localparam logic [8:0] I_LW     = 9'b0_0000_1001;
  localparam logic [8:0] I_SW     = 9'b0_0001_0000;
  localparam logic [8:0] I_ECALL  = 9'b0_0010_0000;
  localparam logic [8:0] I_EBREAK = 9'b0_0100_0000;
  localparam logic [8:0] I_MRET   = 9'b0_1000_0000;
  localparam logic [8:0] I_ILLJAL = 9'b1_0000_0011;

  // Output vector: {ready, cc, rf_we, pc_we, sel[1:0], flush, req, trap, cause[3:0], mret, retire}
  function automatic logic [14:0] pk(logic rdy, logic cc, logic rw, logic pw, logic [1:0] sel,
                                     logic fl, logic rq, logic tr, logic [3:0] ca,
                                     logic mr, logic rt);
    return {rdy, cc, rw, pw, sel, fl, rq, tr, ca, mr, rt};
  endfunction

  function automatic logic [14:0] outs();
    return {bus_if.instr_ready, cc_o, rf_we_o, pc_we_o, pc_sel_o, flush_o,
            bus_if.lsu_req, trap_o, cause_o, mret_o, retire_o};
  endfunction

  task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Drives one cycle of stimulus just after a rising edge, checks at the falling edge,
  // then advances to just after the next rising edge.
  task automatic cyc(input string tag, input logic valid, input logic [8:0] ins,
                     input logic tk, input logic gnt, input logic rv, input logic [14:0] exp);
    bus_if.instr_valid = valid;
    {illegal, mret, ebreak, ecall, st, ld, branch, jump, rf_we} = ins;
    taken             = tk;
    bus_if.lsu_gnt    = gnt;
    bus_if.lsu_rvalid = rv;
    #4;
    check_eq(tag, outs(), exp);
    @(posedge clk);
    #1;
  endtask

  logic [14:0] z, ret_seq, ret_ld, ret_jmp, req1;

  initial begin
    z       = pk(0,0,0,0,2'd0,0,0,0,4'd0,0,0);
    ret_seq = pk(1,0,0,1,2'd0,0,0,0,4'd0,0,1);
    ret_ld  = pk(1,0,1,1,2'd0,0,0,0,4'd0,0,1);
    ret_jmp = pk(1,1,0,1,2'd1,1,0,0,4'd0,0,1);
    req1    = pk(0,0,0,0,2'd0,0,1,0,4'd0,0,0);

    #1;
    // Reset holds every output low even with a valid ADDI presented.
    cyc("reset_outs", 1, I_ADDI, 0, 0, 0, z);
    rst = 1'b0;

    cyc("idle", 0, I_ADDI, 0, 0, 0, z);
    cyc("addi", 1, I_ADDI, 0, 0, 0, ret_ld);

    cyc("jal_c0", 1, I_JAL, 0, 0, 0, pk(0,0,1,0,2'd0,0,0,0,4'd0,0,0));
    cyc("jal_c1", 1, I_JAL, 0, 0, 0, ret_jmp);

    cyc("beq_nt", 1, I_BEQ, 0, 0, 0, ret_seq);
    cyc("beq_t_c0", 1, I_BEQ, 1, 0, 0, z);
    cyc("beq_t_c1", 1, I_BEQ, 1, 0, 0, ret_jmp);

    // LW: req 2 cycles (stray rvalid ignored in MEM_REQ), gnt ignored in MEM_WAIT,
    // rvalid arrives as the counter reaches the timeout and still completes.
    cyc("lw_c0", 1, I_LW, 0, 0, 0, z);
    cyc("lw_c1", 1, I_LW, 0, 0, 1, req1);
    cyc("lw_c2", 1, I_LW, 0, 1, 0, req1);
    cyc("lw_c3", 1, I_LW, 0, 1, 0, z);
    cyc("lw_c4", 1, I_LW, 0, 0, 0, z);
    cyc("lw_c5", 1, I_LW, 0, 0, 1, ret_ld);

    // SW without grant: timeout trap, cause 7, in cycle 5.
    cyc("sw_c0", 1, I_SW, 0, 0, 0, z);
    for (int i = 1; i <= 4; i++) cyc($sformatf("sw_c%0d", i), 1, I_SW, 0, 0, 0, req1);
    cyc("sw_trap", 1, I_SW, 0, 0, 0, pk(1,0,0,1,2'd2,1,0,1,4'd7,0,0));
    cyc("sw_stray_rv", 0, I_NONE, 0, 0, 1, z);
    cyc("after_sw", 1, I_ADDI, 0, 0, 0, ret_ld);

    // LW granted then never completed: timeout in MEM_WAIT, cause 5, no RF write.
    cyc("lwto_c0", 1, I_LW, 0, 0, 0, z);
    cyc("lwto_c1", 1, I_LW, 0, 1, 0, req1);
    for (int i = 2; i <= 4; i++) cyc($sformatf("lwto_c%0d", i), 1, I_LW, 0, 0, 0, z);
    cyc("lwto_trap", 1, I_LW, 0, 0, 0, pk(1,0,0,1,2'd2,1,0,1,4'd5,0,0));

    cyc("ecall", 1, I_ECALL, 0, 0, 0, pk(1,0,0,1,2'd2,1,0,1,4'd11,0,0));
    cyc("ebreak", 1, I_EBREAK, 0, 0, 0, pk(1,0,0,1,2'd2,1,0,1,4'd3,0,0));
    cyc("mret", 1, I_MRET, 0, 0, 0, pk(1,0,0,1,2'd3,1,0,0,4'd0,1,1));
    cyc("illegal_jal", 1, I_ILLJAL, 0, 0, 0, pk(1,0,0,1,2'd2,1,0,1,4'd2,0,0));
    cyc("after_ill", 1, I_ADDI, 0, 0, 0, ret_ld);

    // Reset while in MEM_WAIT abandons the load; next ADDI decodes from EXEC.
    cyc("rstw_c0", 1, I_LW, 0, 0, 0, z);
    cyc("rstw_c1", 1, I_LW, 0, 1, 0, req1);
    rst = 1'b1;
    cyc("rstw_rst", 1, I_LW, 0, 0, 1, z);
    rst = 1'b0;
    cyc("rstw_addi", 1, I_ADDI, 0, 0, 0, ret_ld);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
